// File: rtl/brick_collision_engine.sv
// Sequential ball/brick collision resolver: edge test, then a one-brick-per-cycle scan
// of the grid, then a registered result with brick clearing and live-brick accounting.
module brick_collision_engine #(
    parameter int ROWS     = 3,
    parameter int COLS     = 4,
    parameter int BRICK_W  = 120,
    parameter int BRICK_H  = 40,
    parameter int GAP      = 20,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    localparam int NB      = ROWS * COLS,
    localparam int IW      = $clog2(NB)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          load_level,
    input  logic [9:0]    ball_x,
    input  logic [9:0]    ball_y,
    input  logic [1:0]    dir,
    input  logic [6:0]    xstep,
    input  logic [6:0]    ystep,
    output logic          busy,
    output logic          done,
    output logic [1:0]    collision,
    output logic [1:0]    new_dir,
    output logic          brick_hit,
    output logic [IW-1:0] brick_idx,
    output logic          ball_lost,
    output logic [NB-1:0] bricks_alive,
    output logic [IW:0]   bricks_left,
    output logic          cleared
);

    // Wide enough that ball+step and ball-step never wrap for any 10-bit input.
    localparam int PW = 13;
    localparam logic signed [PW-1:0] ZERO = '0;
    localparam logic signed [PW-1:0] XMAX = PW'(SCREEN_W - 1);
    localparam logic signed [PW-1:0] YMAX = PW'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, EDGE, SCAN, RESOLVE} state_t;

    state_t state, state_nx;

    logic signed [PW-1:0] nx_r, ny_r, ly_r;
    logic [1:0]           dir_r;
    logic                 hit_r, axis_r, lost_r, bhit_r;
    logic [IW-1:0]        bidx_r;
    logic [IW-1:0]        scan_idx, scan_col, scan_row;

    logic signed [PW-1:0] bx0, bx1, by0, by1;
    logic                 x_hit, y_hit, y_lost, in_rect, y_in, brick_sel;
    logic                 accept, res_fire;

    function automatic logic signed [PW-1:0] next_pos(input logic [9:0] pos,
                                                      input logic [6:0] step,
                                                      input logic       neg);
        logic signed [PW-1:0] p, s;
        p = $signed({3'b000, pos});
        s = $signed({6'b000000, step});
        return neg ? (p - s) : (p + s);
    endfunction

    assign accept   = (state == IDLE) && start && !load_level;
    assign res_fire = (state == RESOLVE) && !load_level;
    assign cleared  = (bricks_left == '0);

    // Edge and brick geometry tests against the latched next position
    always_comb begin
        bx0 = PW'(GAP + int'(scan_col) * (BRICK_W + GAP));
        by0 = PW'(GAP + int'(scan_row) * (BRICK_H + GAP));
        bx1 = bx0 + PW'(BRICK_W);
        by1 = by0 + PW'(BRICK_H);
        x_hit  = dir_r[0] ? (nx_r <= ZERO) : (nx_r >= XMAX);
        y_lost = !dir_r[1] && (ny_r >= YMAX);
        y_hit  = dir_r[1] ? (ny_r <= ZERO) : y_lost;
        in_rect = (nx_r >= bx0) && (nx_r <= bx1) && (ny_r >= by0) && (ny_r <= by1);
        y_in    = (ly_r >= by0) && (ly_r <= by1);
        brick_sel = (state == SCAN) && bricks_alive[scan_idx] && in_rect && !hit_r;
    end

    always_comb begin
        state_nx = state;
        if (load_level) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = EDGE;
                EDGE:    state_nx = (x_hit || y_hit) ? RESOLVE : SCAN;
                SCAN:    if (scan_idx == IW'(NB - 1)) state_nx = RESOLVE;
                RESOLVE: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Latched request and pending result; cleared on every accepted start
    always_ff @(posedge clk) begin
        if (accept) begin
            nx_r   <= next_pos(ball_x, xstep, dir[0]);
            ny_r   <= next_pos(ball_y, ystep, dir[1]);
            ly_r   <= $signed({3'b000, ball_y});
            dir_r  <= dir;
            hit_r  <= 1'b0;
            axis_r <= 1'b0;
            lost_r <= 1'b0;
            bhit_r <= 1'b0;
            bidx_r <= '0;
        end else if (state == EDGE) begin
            scan_idx <= '0;
            scan_col <= '0;
            scan_row <= '0;
            if (x_hit) begin
                hit_r <= 1'b1;
            end else if (y_hit) begin
                hit_r  <= 1'b1;
                axis_r <= 1'b1;
                lost_r <= y_lost;
            end
        end else if (state == SCAN) begin
            if (brick_sel) begin
                hit_r  <= 1'b1;
                bhit_r <= 1'b1;
                bidx_r <= scan_idx;
                axis_r <= !y_in;
            end
            scan_idx <= scan_idx + 1'b1;
            if (scan_col == IW'(COLS - 1)) begin
                scan_col <= '0;
                scan_row <= scan_row + 1'b1;
            end else begin
                scan_col <= scan_col + 1'b1;
            end
        end
    end

    // Registered results and brick bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            collision    <= 2'b00;
            new_dir      <= 2'b00;
            brick_hit    <= 1'b0;
            brick_idx    <= '0;
            ball_lost    <= 1'b0;
            bricks_alive <= '1;
            bricks_left  <= (IW+1)'(NB);
        end else begin
            done <= res_fire;
            if (load_level)    busy <= 1'b0;
            else if (accept)   busy <= 1'b1;
            else if (res_fire) busy <= 1'b0;
            if (res_fire) begin
                collision <= {hit_r, hit_r & axis_r};
                new_dir   <= !hit_r ? dir_r : (axis_r ? (dir_r ^ 2'b10) : (dir_r ^ 2'b01));
                brick_hit <= bhit_r;
                brick_idx <= bidx_r;
                ball_lost <= lost_r;
            end
            if (load_level) begin
                bricks_alive <= '1;
                bricks_left  <= (IW+1)'(NB);
            end else if (res_fire && bhit_r) begin
                bricks_alive[bidx_r] <= 1'b0;
                bricks_left          <= bricks_left - 1'b1;
            end
        end
    end

endmodule
